// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the main-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I)
//   arb_src_t   : request source (SRC_IF = fetch, SRC_DM = data)
//   MEM_LAT_MIN/MEM_LAT_MAX : legal range of the memory latency parameter
//   CNT_W       : latency counter width, wide enough for the largest latency
//   lat_load()  : counter preload value for a given latency, clamped to range
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_D,
        BUSY_I,
        RESP_D,
        RESP_I
    } arb_state_t;

    typedef enum logic {
        SRC_IF,
        SRC_DM
    } arb_src_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = $clog2(16);

    // The counter runs MEM_LATENCY-1 .. 0, so BUSY lasts exactly MEM_LATENCY
    // cycles. Out-of-range latencies are clamped rather than wrapped.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        int l;
        l = (lat < MEM_LAT_MIN) ? MEM_LAT_MIN :
            (lat > MEM_LAT_MAX) ? MEM_LAT_MAX : lat;
        return CNT_W'(l - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Loadable down-counter with a zero flag, used to time a memory access.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : preload value
//   dec        : decrement by one; saturates at zero
//   zero       : count is zero
// -----------------------------------------------------------------------------
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is only ever written with non-blocking (<=)
    // assignments so every flop samples pre-edge values, whatever order the
    // simulator evaluates the always blocks in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// and the data-memory stage. Data requests win ties (older instruction).
//
// Parameters: MEM_LATENCY (1..15), ADDR_W, DATA_W
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   if_req_i / if_addr_i       : fetch request (held until if_done_o)
//   if_rdata_o / if_done_o     : fetched word (held) and one-cycle done pulse
//   if_stall_o                 : freeze PC and IF/ID
//   dm_req_i/dm_wr_i/dm_addr_i/dm_wdata_i : data request (held until dm_done_o)
//   dm_rdata_o / dm_done_o     : load data (held) and one-cycle done pulse
//   dm_stall_o                 : freeze EX/MEM and earlier
//   err_o                      : one-cycle unaligned-access flag
//   mem_req_o/mem_wr_o/mem_addr_o/mem_wdata_o : memory strobe and request
//   mem_rdata_i                : memory read data, valid in the last BUSY cycle
//
// Build option: define MEM_PORT_ARB_ALIGN_CHK_EN to reject odd addresses
// (no memory access, err_o with done, rdata unchanged). Without it addr[0]
// passes through and err_o is tied low.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_wr_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              dm_stall_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LATENCY);

    arb_state_t        state;
    logic              acc_valid;
    arb_src_t          acc_src;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_misal;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    // Request selection seen from IDLE; data wins over fetch.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        acc_valid = dm_req_i | if_req_i;
        acc_src   = dm_req_i ? SRC_DM : SRC_IF;
        acc_addr  = dm_req_i ? dm_addr_i : if_addr_i;
`ifdef MEM_PORT_ARB_ALIGN_CHK_EN
        acc_misal = acc_addr[0];
`else
        acc_misal = 1'b0;
`endif
    end

    assign cnt_load = (state == IDLE) && acc_valid && !acc_misal;
    assign cnt_dec  = (state == BUSY_D) || (state == BUSY_I);

    mem_lat_counter u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // The rdata holding registers are cleared too: every output must
            // read 0 straight out of reset.
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_done_o   <= 1'b0;
            dm_done_o   <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
`ifdef MEM_PORT_ARB_ALIGN_CHK_EN
            err_o       <= 1'b0;
`endif
        end else begin
            // Done and err are single-cycle pulses.
            if_done_o <= 1'b0;
            dm_done_o <= 1'b0;
`ifdef MEM_PORT_ARB_ALIGN_CHK_EN
            err_o     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (acc_valid) begin
                        if (acc_misal) begin
                            // Rejected access skips memory and completes at once.
                            state <= (acc_src == SRC_DM) ? RESP_D : RESP_I;
                            if (acc_src == SRC_DM) dm_done_o <= 1'b1;
                            else                   if_done_o <= 1'b1;
`ifdef MEM_PORT_ARB_ALIGN_CHK_EN
                            err_o <= 1'b1;
`endif
                        end else begin
                            // Latch the request; memory outputs stay frozen for
                            // the whole BUSY period regardless of input changes.
                            state      <= (acc_src == SRC_DM) ? BUSY_D : BUSY_I;
                            mem_req_o  <= 1'b1;
                            mem_wr_o   <= (acc_src == SRC_DM) && dm_wr_i;
                            mem_addr_o <= acc_addr;
                            if (acc_src == SRC_DM) mem_wdata_o <= dm_wdata_i;
                        end
                    end
                end
                BUSY_D: begin
                    if (cnt_zero) begin
                        if (!mem_wr_o) dm_rdata_o <= mem_rdata_i;
                        mem_req_o <= 1'b0;
                        mem_wr_o  <= 1'b0;
                        dm_done_o <= 1'b1;
                        state     <= RESP_D;
                    end
                end
                BUSY_I: begin
                    if (cnt_zero) begin
                        if_rdata_o <= mem_rdata_i;
                        mem_req_o  <= 1'b0;
                        if_done_o  <= 1'b1;
                        state      <= RESP_I;
                    end
                end
                RESP_D, RESP_I: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MEM_PORT_ARB_ALIGN_CHK_EN
    assign err_o = 1'b0;
`endif

    // Stalls must react in the same cycle a request appears.
    assign if_stall_o = if_req_i & ~if_done_o;
    assign dm_stall_o = dm_req_i & ~dm_done_o;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported, fixed-latency main memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Each request is sequenced through a small state machine with a latency counter. The block returns read data with a one-cycle done pulse and drives the per-stage stall signals that freeze PC and pipeline registers while an access is outstanding. Data-stage requests take priority over fetch because they belong to the older instruction.

## Interface
Parameters:
- MEM_LATENCY, 4, cycles from memory request to valid read data; legal range 1..15
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req_i  in  1  fetch request; held until if_done_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction; valid with if_done_o, holds until next fetch completion
- if_done_o  out  1  one-cycle completion pulse for fetch
- if_stall_o  out  1  freeze PC and IF/ID
- dm_req_i  in  1  data request (DMemEn); held until dm_done_o
- dm_wr_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data; valid with dm_done_o, holds until next data load completion
- dm_done_o  out  1  one-cycle completion pulse for data
- dm_stall_o  out  1  freeze EX/MEM and earlier stages
- err_o  out  1  one-cycle unaligned-access flag (see Configuration)
- mem_req_o, mem_wr_o  out  1 each  memory strobe and write enable
- mem_addr_o, mem_wdata_o  out  ADDR_W, DATA_W  memory address and write data
- mem_rdata_i  in  DATA_W  memory read data; valid MEM_LATENCY cycles after the first mem_req_o cycle

## Operation
- States: IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I.
- IDLE:
  - dm_req_i=1: latch addr/wr/wdata, enter BUSY_D.
  - Else if_req_i=1: latch addr, enter BUSY_I.
  - Simultaneous requests: data is served first and fetch stays pending.
- BUSY_x:
  - mem_req_o=1, and memory outputs are driven from the latched request and are stable throughout.
  - Counter loads MEM_LATENCY-1 on entry and decrements each cycle.
  - At 0: capture mem_rdata_i into the x rdata register (loads and fetches only), then enter RESP_x.
- RESP_x: x_done_o=1 for exactly one cycle, then IDLE. A pending request from the other port is accepted on the following IDLE cycle.
- Stores: complete with dm_done_o, and dm_rdata_o is unchanged.
- Stalls are combinational: if_stall_o = if_req_i & ~if_done_o; dm_stall_o = dm_req_i & ~dm_done_o.
- Requester rule: the requester deasserts req the cycle after done. If req is still high in IDLE, it is treated as a new request.
- Request inputs that change during BUSY are ignored.

## Timing
- Reset:
  - State goes to IDLE and the counter to 0.
  - All outputs are 0, including the rdata registers, mem_* and done.
  - Reset asserted mid-access aborts it: mem_req_o is low after that edge, no done is issued, and stall follows req_i.
- Latency: request sampled at edge 0 gives mem_req_o for cycles 1..MEM_LATENCY, and done in cycle MEM_LATENCY+1.
- Back-to-back on the same port: at most one access per MEM_LATENCY+2 cycles.
- With MEM_LATENCY=1: BUSY lasts exactly one cycle and the counter never decrements.
- Worst-case fetch wait behind a data access: 2*(MEM_LATENCY+2) cycles.

## Configuration
- MEM_PORT_ARB_ALIGN_CHK_EN defined:
  - A request with addr[0]=1 goes directly IDLE -> RESP_x with no mem_req_o.
  - err_o pulses together with done, and the rdata registers are unchanged.
- Undefined:
  - addr[0] is passed through unchanged.
  - err_o is tied 0.

## Structure
- Package mem_arb_pkg holds:
  - the state enum;
  - the source enum (SRC_IF, SRC_DM);
  - the MEM_LATENCY range constants.
- Sub-module mem_lat_counter: a loadable down-counter with a zero flag, width $clog2(16).

## Test plan
- Single load, MEM_LATENCY=4: dm_req at addr 0x0010 with memory returning 0xBEEF gives mem_req_o in cycles 1-4, dm_done_o plus dm_rdata_o=0xBEEF in cycle 5, and dm_stall_o high in cycles 0-4.
- Simultaneous if_req and dm_req: data is served first (done in cycle 5), then fetch is accepted in cycle 6 with if_done_o in cycle 11, and if_stall_o is high in cycles 0-10.
- Store of 0x1234 to 0x0020: mem_wr_o=1 and mem_wdata_o=0x1234 in cycles 1-4, dm_done_o in cycle 5, and dm_rdata_o keeps its prior value.
- rst_n low in cycle 2 of a fetch: mem_req_o is 0 in cycle 3, there is no if_done_o, and a refetch after release completes normally.
- MEM_LATENCY=1: a fetch completes with done in cycle 2, and mem_req_o is high only in cycle 1.
- With MEM_PORT_ARB_ALIGN_CHK_EN, dm_req at addr 0x0011: err_o and dm_done_o in cycle 1, and mem_req_o never asserts.
